// File: rtl/pipe_stage_elastic.sv
// Two-entry elastic pipeline stage (main + skid register) with registered state.
// Optional performance counters (stall_cnt, bubble_cnt) are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_elastic #(
    parameter int DATA_W = 160,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    // State values are chosen to equal the number of held entries.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              in_fire;
    logic              out_fire;

    // in_ready is gated by reset so upstream never sees a ready stage while reset is held.
    assign in_ready  = ~reset & (state != FULL);
    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign occupancy = 2'(state);

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: the payload registers are reset as well, because out_data must read 0 during reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state  <= ONE;
                        main_q <= in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data;
                    end else if (in_fire) begin
                        state  <= FULL;
                        skid_q <= in_data;
                    end else if (out_fire) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state  <= ONE;
                        main_q <= skid_q;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Saturating counters; flush deliberately leaves them untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (out_ready && !out_valid && bubble_cnt != CNT_MAX)
                bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end
`else
    wire unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: directed scenarios plus random traffic checked against a
// two-deep FIFO reference model; counter checks are compiled when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_elastic;

    localparam int W  = 160;
    localparam int CW = 4;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [1:0]    occupancy;
`ifdef PIPE_STAGE_PERF_EN
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] bubble_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: queue of accepted payloads (capacity 2) and counter values.
    logic [W-1:0] mq[$];
    int           m_stall;
    int           m_bubble;

    pipe_stage_elastic #(.DATA_W(W), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .occupancy  (occupancy)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_model();
        check("in_ready", W'(in_ready), W'(mq.size() < 2));
        check("out_valid", W'(out_valid), W'(mq.size() > 0));
        check("occupancy", W'(occupancy), W'(mq.size()));
        if (mq.size() > 0)
            check("out_data", out_data, mq[0]);
`ifdef PIPE_STAGE_PERF_EN
        check("stall_cnt", W'(stall_cnt), W'(m_stall));
        check("bubble_cnt", W'(bubble_cnt), W'(m_bubble));
`endif
    endtask

    task automatic model_update(input logic v, input logic [W-1:0] d, input logic r, input logic f);
        int  n;
        logic can_take;
        logic has_out;
        n        = mq.size();
        can_take = (n < 2);
        has_out  = (n > 0);
        if (has_out && !r && m_stall < (2**CW - 1))
            m_stall++;
        if (!has_out && r && m_bubble < (2**CW - 1))
            m_bubble++;
        if (f) begin
            mq.delete();
        end else begin
            if (has_out && r)
                void'(mq.pop_front());
            if (v && can_take)
                mq.push_back(d);
        end
    endtask

    // One clock cycle: drive inputs, let the edge happen, advance the model, check at negedge.
    task automatic step(input logic v, input logic [W-1:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        model_update(v, d, r, f);
        @(negedge clk);
        check_model();
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        m_stall   = 0;
        m_bubble  = 0;

        #1;
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_out_data", out_data, W'(0));
        check("rst_occupancy", W'(occupancy), W'(0));
        check("rst_in_ready", W'(in_ready), W'(0));

        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rel_in_ready", W'(in_ready), W'(1));

        // Streaming at full rate: each payload shows up one cycle after acceptance.
        step(1'b1, W'(1), 1'b1, 1'b0);
        check("stream_d1", out_data, W'(1));
        check("stream_occ1", W'(occupancy), W'(1));
        step(1'b1, W'(2), 1'b1, 1'b0);
        check("stream_d2", out_data, W'(2));
        step(1'b1, W'(3), 1'b1, 1'b0);
        check("stream_d3", out_data, W'(3));
        check("stream_occ3", W'(occupancy), W'(1));
        step(1'b0, '0, 1'b1, 1'b0);

        // Backpressure: fill both entries, hold, then drain in order.
        step(1'b1, W'('hA), 1'b0, 1'b0);
        step(1'b1, W'('hB), 1'b0, 1'b0);
        check("bp_occ", W'(occupancy), W'(2));
        check("bp_in_ready", W'(in_ready), W'(0));
        check("bp_data", out_data, W'('hA));
        step(1'b1, W'('hF), 1'b0, 1'b0);
        check("bp_stable", out_data, W'('hA));
        step(1'b0, '0, 1'b1, 1'b0);
        check("bp_pop_b", out_data, W'('hB));
        check("bp_ready_back", W'(in_ready), W'(1));
        step(1'b0, '0, 1'b1, 1'b0);
        check("bp_drained", W'(out_valid), W'(0));

        // Flush while full with a simultaneous push: everything discarded.
        step(1'b1, W'('hA), 1'b0, 1'b0);
        step(1'b1, W'('hB), 1'b0, 1'b0);
        step(1'b1, W'('hC), 1'b0, 1'b1);
        check("flush_valid", W'(out_valid), W'(0));
        check("flush_occ", W'(occupancy), W'(0));
        step(1'b0, '0, 1'b1, 1'b0);
        check("flush_no_c", W'(out_valid), W'(0));

        // Flush while empty only drops the simultaneous push.
        step(1'b1, W'('hD), 1'b1, 1'b1);
        check("flush_empty", W'(occupancy), W'(0));

        // Random traffic against the model.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), rnd_data(), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 19) == 0));

        // Asynchronous reset mid-cycle while full.
        step(1'b1, W'('hA), 1'b0, 1'b0);
        step(1'b1, W'('hB), 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("areset_out_valid", W'(out_valid), W'(0));
        check("areset_out_data", out_data, W'(0));
        check("areset_occ", W'(occupancy), W'(0));
        check("areset_in_ready", W'(in_ready), W'(0));
        mq.delete();
        m_stall  = 0;
        m_bubble = 0;
`ifdef PIPE_STAGE_PERF_EN
        check("areset_stall", W'(stall_cnt), W'(0));
        check("areset_bubble", W'(bubble_cnt), W'(0));
`endif
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rel2_in_ready", W'(in_ready), W'(1));

`ifdef PIPE_STAGE_PERF_EN
        // Counter saturation, bubble counting and flush immunity.
        step(1'b1, W'('h5), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++)
            step(1'b0, '0, 1'b0, 1'b0);
        check("perf_stall_sat", W'(stall_cnt), W'(15));
        step(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b0, '0, 1'b1, 1'b0);
        check("perf_bubble3", W'(bubble_cnt), W'(3));
        step(1'b0, '0, 1'b0, 1'b1);
        check("perf_flush_stall", W'(stall_cnt), W'(15));
        check("perf_flush_bubble", W'(bubble_cnt), W'(3));
`endif

        step(1'b0, '0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_elastic.md
PIPE_STAGE_ELASTIC -- requirements
Module: pipe_stage_elastic

Interface
REQ-001 Parameter DATA_W, default 160, payload width in bits (pc, operands, imm, control bits concatenated by the instantiating stage).
REQ-002 Parameter CNT_W, default 16, width of each performance counter.
REQ-003 Port clk  input  1  rising-edge clock.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port flush  input  1  synchronous discard of all held entries (branch mispredict / trap).
REQ-006 Port in_valid  input  1  upstream payload valid.
REQ-007 Port in_ready  output  1  stage can accept a payload this cycle.
REQ-008 Port in_data  input  DATA_W  upstream payload.
REQ-009 Port out_valid  output  1  out_data holds a valid payload.
REQ-010 Port out_ready  input  1  downstream accepts the payload this cycle.
REQ-011 Port out_data  output  DATA_W  oldest held payload.
REQ-012 Port occupancy  output  2  number of held entries (0, 1 or 2).
REQ-013 Port stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0 (present only with PIPE_STAGE_PERF_EN).
REQ-014 Port bubble_cnt  output  CNT_W  cycles with out_ready=1 and out_valid=0 (present only with PIPE_STAGE_PERF_EN).

Function
REQ-015 The block SHALL be a two-entry skid buffer (main register, skid register) with a state machine EMPTY, ONE, FULL; occupancy SHALL equal 0/1/2 respectively.
REQ-016 The block SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-017 in_ready SHALL be (state != FULL) and SHALL be 0 while reset is asserted; out_valid SHALL be (state != EMPTY); out_data SHALL be the main register.
REQ-018 EMPTY: in_fire -> ONE, main <= in_data; otherwise hold.
REQ-019 ONE: in_fire & out_fire -> ONE, main <= in_data; in_fire only -> FULL, skid <= in_data; out_fire only -> EMPTY; neither -> hold.
REQ-020 FULL: out_fire -> ONE, main <= skid; otherwise hold; no in_fire is possible in FULL.
REQ-021 Latency SHALL be exactly 1 cycle from in_fire to out_valid for a payload entering an empty stage; sustained throughput SHALL be one payload per cycle while out_ready=1.
REQ-022 Payloads SHALL leave in acceptance order; no payload SHALL be duplicated or dropped except by flush.
REQ-023 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 flush SHALL have priority over all transitions: next state EMPTY, any in_fire in the same cycle discarded, register contents don't-care but out_valid=0 next cycle.
REQ-025 flush while EMPTY SHALL have no effect other than discarding a simultaneous in_fire.

Reset
REQ-026 On reset the block SHALL enter EMPTY with main and skid registers cleared to 0, giving out_valid=0, out_data=0, occupancy=0, in_ready=0.
REQ-027 The first rising clk edge after reset deassertion SHALL see in_ready=1.
REQ-028 Reset asserted mid-operation SHALL discard all held payloads immediately, independent of clk.
REQ-029 stall_cnt and bubble_cnt SHALL reset to 0; flush SHALL NOT clear them.

Configuration
REQ-030 Macro PIPE_STAGE_PERF_EN defined: stall_cnt and bubble_cnt ports and logic SHALL exist, each incrementing by 1 per qualifying cycle and saturating at all-ones (2^CNT_W-1), not counting while reset is asserted.
REQ-031 Macro PIPE_STAGE_PERF_EN undefined: those ports and counters SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 Reset release, out_ready=1, in_valid=1 with data 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 on the next three cycles, occupancy stays 1.
REQ-033 out_ready=0, push 0xA then 0xB -> occupancy 2, in_ready=0, out_data=0xA stable; raise out_ready -> 0xA then 0xB delivered, in_ready=1 one cycle after first pop.
REQ-034 FULL with 0xA,0xB, assert flush with in_valid=1 data 0xC -> next cycle out_valid=0, occupancy 0, 0xC never appears.
REQ-035 Assert reset asynchronously mid-cycle while FULL -> out_valid, out_data, occupancy, in_ready all 0 before next clk edge.
REQ-036 PIPE_STAGE_PERF_EN, CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt saturates at 15; 3 cycles out_ready=1 empty -> bubble_cnt=3; flush leaves both unchanged.
